ioctl_sender: RTL and testbench

Simulation-side transmitter for the HPS-style ioctl bus that the core top levels receive. It plays the role of the MiSTer framework, with two session types:
- **Download:** pulls bytes from a byte source and drives `ioctl_download`, `ioctl_index`, `ioctl_addr`, `ioctl_dout` and `ioctl_wr`, honouring `ioctl_wait`.
- **Upload:** walks `ioctl_addr` and returns `ioctl_din` bytes to a sink, which is how the bench reads back hiscore NVRAM.

It sits in the Verilator harness between the DPI/testbench byte queue and the top-level `ioctl_*` ports.

---
 rtl/ioctl_sender.sv | 170 +++++++++++++++++
 tb/tb_ioctl_sender.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_sender.sv
// Simulation-side MiSTer ioctl transmitter: streams download bytes from a source
// onto the ioctl bus and reads upload bytes back from the core into a sink.
module ioctl_sender #(
   parameter int SETUP  = 2,
   parameter int WR_GAP = 4,
   parameter int HOLD   = 2,
   parameter int RD_LAT = 2
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        start,
   input  logic        dir,
   input  logic [7:0]  index,
   input  logic [24:0] length,
   output logic        busy,
   output logic        done,
   output logic        src_req,
   input  logic        src_valid,
   input  logic [7:0]  src_data,
   output logic        snk_valid,
   output logic [24:0] snk_addr,
   output logic [7:0]  snk_data,
   output logic        ioctl_download,
   output logic        ioctl_upload,
   output logic [7:0]  ioctl_index,
   output logic        ioctl_wr,
   output logic [24:0] ioctl_addr,
   output logic [7:0]  ioctl_dout,
   input  logic        ioctl_wait,
   input  logic [7:0]  ioctl_din
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_FETCH = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;
   localparam logic [2:0] S_READ  = 3'd5;
   localparam logic [2:0] S_HOLD  = 3'd6;
   localparam logic [2:0] S_END   = 3'd7;

   // GAP includes the ioctl_wr cycle itself, so it terminates at WR_GAP rather than WR_GAP-1.
   localparam logic [7:0] SETUP_LAST = 8'(SETUP - 1);
   localparam logic [7:0] GAP_LAST   = 8'(WR_GAP);
   localparam logic [7:0] HOLD_LAST  = 8'(HOLD - 1);
   localparam logic [7:0] RD_LAST    = 8'(RD_LAT);

   logic [2:0]  state;
   logic [7:0]  cnt;
   logic [24:0] remaining;
   logic        up;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         cnt            <= '0;
         remaining      <= '0;
         up             <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         src_req        <= 1'b0;
         snk_valid      <= 1'b0;
         snk_addr       <= '0;
         snk_data       <= '0;
         ioctl_download <= 1'b0;
         ioctl_upload   <= 1'b0;
         ioctl_index    <= '0;
         ioctl_wr       <= 1'b0;
         ioctl_addr     <= '0;
         ioctl_dout     <= '0;
      end else begin
         done      <= 1'b0;
         ioctl_wr  <= 1'b0;
         snk_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  up             <= dir;
                  remaining      <= length;
                  ioctl_addr     <= '0;
                  ioctl_download <= ~dir;
                  ioctl_upload   <= dir;
                  ioctl_index    <= index;
                  busy           <= 1'b1;
                  cnt            <= '0;
                  state          <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (cnt == SETUP_LAST) begin
                  cnt <= '0;
                  if (remaining == 25'd0) begin
                     state <= S_HOLD;
                  end else if (up) begin
                     state <= S_READ;
                  end else begin
                     state   <= S_FETCH;
                     src_req <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_FETCH: begin
               if (src_valid) begin
                  ioctl_dout <= src_data;
                  src_req    <= 1'b0;
                  state      <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (!ioctl_wait) begin
                  ioctl_wr <= 1'b1;
                  cnt      <= '0;
                  state    <= S_GAP;
               end
            end
            S_GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt        <= '0;
                  ioctl_addr <= ioctl_addr + 25'd1;
                  remaining  <= remaining - 25'd1;
                  if (remaining == 25'd1) begin
                     state <= S_HOLD;
                  end else begin
                     state   <= S_FETCH;
                     src_req <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_READ: begin
               // Let the core's read pipeline settle before honouring its stall request.
               if (cnt != RD_LAST) begin
                  cnt <= cnt + 8'd1;
               end else if (!ioctl_wait) begin
                  snk_valid  <= 1'b1;
                  snk_addr   <= ioctl_addr;
                  snk_data   <= ioctl_din;
                  cnt        <= '0;
                  ioctl_addr <= ioctl_addr + 25'd1;
                  remaining  <= remaining - 25'd1;
                  if (remaining == 25'd1) begin
                     state <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (cnt == HOLD_LAST) begin
                  cnt            <= '0;
                  ioctl_download <= 1'b0;
                  ioctl_upload   <= 1'b0;
                  ioctl_index    <= '0;
                  state          <= S_END;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_END: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ioctl_sender.sv
// Scoreboard bench for ioctl_sender: a reference model queues the expected ioctl
// writes, sink bytes and done pulses; a negedge monitor pops and compares them.
module tb_ioctl_sender;

   localparam int SETUP  = 2;
   localparam int WR_GAP = 4;
   localparam int HOLD   = 2;
   localparam int RD_LAT = 2;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        dir = 1'b0;
   logic [7:0]  index = '0;
   logic [24:0] length = '0;
   logic        busy, done, src_req, snk_valid;
   logic        src_valid = 1'b0;
   logic [7:0]  src_data = '0;
   logic [24:0] snk_addr;
   logic [7:0]  snk_data;
   logic        ioctl_download, ioctl_upload, ioctl_wr;
   logic [7:0]  ioctl_index, ioctl_dout;
   logic [24:0] ioctl_addr;
   logic        ioctl_wait = 1'b0;
   logic [7:0]  ioctl_din = '0;

   ioctl_sender #(.SETUP(SETUP), .WR_GAP(WR_GAP), .HOLD(HOLD), .RD_LAT(RD_LAT)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .dir(dir), .index(index),
      .length(length), .busy(busy), .done(done), .src_req(src_req), .src_valid(src_valid),
      .src_data(src_data), .snk_valid(snk_valid), .snk_addr(snk_addr), .snk_data(snk_data),
      .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
      .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .ioctl_wait(ioctl_wait), .ioctl_din(ioctl_din)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic [24:0] addr;
      logic [7:0]  data;
      logic [7:0]  idx;
   } ev_t;

   ev_t        expWr[$];
   ev_t        expSnk[$];
   ev_t        mon;
   logic [7:0] srcBytes[$];
   int         wrCycles[$];
   int         expDone, srcPos, cycle;
   int         checks, errors;
   int         wrCount, snkCount, doneCount, flagCycles, srcReqCycles;
   int         startCycle, releaseCycle, basePos, doneBefore;
   bit         srcAlways, waitRandom, waitForce;
   logic [7:0] dinOffset = 8'h10;
   logic [7:0] dinPipe = '0;

   // Cycle counter and source consumption, both observed at the DUT's sampling edge.
   always @(posedge clk_sys) begin
      cycle++;
      if (reset_n && src_req && src_valid) srcPos++;
   end

   always @(negedge clk_sys) begin
      src_valid = srcAlways ? 1'b1 : ($urandom_range(0, 2) != 0);
      src_data  = (srcPos < srcBytes.size()) ? srcBytes[srcPos] : 8'hEE;
   end

   // Core-side read model: ioctl_din follows ioctl_addr through a short pipeline.
   always @(negedge clk_sys) begin
      ioctl_din = dinPipe;
      dinPipe   = ioctl_addr[7:0] + dinOffset;
   end

   always begin
      @(negedge clk_sys);
      #1;
      ioctl_wait = waitForce | (waitRandom && ($urandom_range(0, 3) == 0));
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: every DUT output event is matched against the head of its expectation queue.
   always @(negedge clk_sys) begin
      if (reset_n) begin
         if (ioctl_download || ioctl_upload) flagCycles++;
         if (src_req) srcReqCycles++;
         if (ioctl_wr) begin
            wrCount++;
            wrCycles.push_back(cycle);
            if (expWr.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_wr: addr 0x%0h dout 0x%0h, expected no write", ioctl_addr, ioctl_dout);
            end else begin
               mon = expWr.pop_front();
               checkOutput("wr_addr", 32'(ioctl_addr), 32'(mon.addr));
               checkOutput("wr_dout", 32'(ioctl_dout), 32'(mon.data));
               checkOutput("wr_index", 32'(ioctl_index), 32'(mon.idx));
               checkOutput("wr_flags", 32'({ioctl_download, ioctl_upload}), 32'd2);
            end
         end
         if (snk_valid) begin
            snkCount++;
            if (expSnk.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_snk: addr 0x%0h data 0x%0h, expected no sink byte", snk_addr, snk_data);
            end else begin
               mon = expSnk.pop_front();
               checkOutput("snk_addr", 32'(snk_addr), 32'(mon.addr));
               checkOutput("snk_data", 32'(snk_data), 32'(mon.data));
               checkOutput("snk_index", 32'(ioctl_index), 32'(mon.idx));
               checkOutput("snk_flags", 32'({ioctl_download, ioctl_upload}), 32'd1);
            end
         end
         if (done) begin
            doneCount++;
            if (expDone == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_done: done at cycle %0d, expected none", cycle);
            end else begin
               expDone--;
               checkOutput("busy_at_done", 32'(busy), 32'd0);
               checkOutput("flags_at_done", 32'({ioctl_download, ioctl_upload}), 32'd0);
            end
         end
      end
   end

   // Builds the expected transcript of a session from its parameters, then issues start.
   task automatic applyStimulus(input bit d, input logic [7:0] idx, input int len,
                                input bit track, input bit seqBytes);
      ev_t ev;
      if (track) begin
         for (int i = 0; i < len; i++) begin
            ev.addr = 25'(i);
            ev.idx  = idx;
            if (!d) begin
               ev.data = seqBytes ? 8'(8'hA0 + i) : 8'($urandom);
               srcBytes.push_back(ev.data);
               expWr.push_back(ev);
            end else begin
               ev.data = 8'(i) + dinOffset;
               expSnk.push_back(ev);
            end
         end
         expDone++;
         wrCycles.delete();
         wrCount = 0;
         snkCount = 0;
         flagCycles = 0;
         srcReqCycles = 0;
      end
      @(negedge clk_sys);
      start  = 1'b1;
      dir    = d;
      index  = idx;
      length = 25'(len);
      @(negedge clk_sys);
      start  = 1'b0;
      dir    = 1'($urandom);
      index  = 8'($urandom);
      length = 25'($urandom);
      if (track) startCycle = cycle;
   endtask

   task automatic waitDone(input int budget);
      int target;
      target = doneCount + 1;
      for (int i = 0; i < budget && doneCount < target; i++) @(negedge clk_sys);
      @(negedge clk_sys);
      checkOutput("session_done", 32'(doneCount >= target), 32'd1);
      checkOutput("wr_queue_drained", 32'(expWr.size()), 32'd0);
      checkOutput("snk_queue_drained", 32'(expSnk.size()), 32'd0);
   endtask

   initial begin
      #1;
      checkOutput("reset_outputs", 32'(|{busy, done, src_req, snk_valid, snk_addr, snk_data,
                  ioctl_download, ioctl_upload, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout}), 32'd0);
      repeat (3) @(negedge clk_sys);
      reset_n = 1'b1;

      // Download of A0..A3 with an always-ready source: fixed byte cadence.
      srcAlways = 1'b1;
      applyStimulus(1'b0, 8'h00, 4, 1'b1, 1'b1);
      waitDone(300);
      checkOutput("first_wr_offset", 32'(wrCycles[0] - startCycle), 32'(SETUP + 2));
      for (int i = 1; i < 4; i++)
         checkOutput("wr_spacing", 32'(wrCycles[i] - wrCycles[i-1]), 32'(WR_GAP + 3));
      checkOutput("dl_wr_count", 32'(wrCount), 32'd4);
      checkOutput("dl_flag_low", 32'(ioctl_download), 32'd0);

      // Stall byte 1 in WRITE for 10 cycles.
      basePos = srcPos;
      applyStimulus(1'b0, 8'h11, 4, 1'b1, 1'b0);
      for (int i = 0; i < 300 && srcPos < basePos + 2; i++) @(negedge clk_sys);
      waitForce = 1'b1;
      repeat (10) @(negedge clk_sys);
      checkOutput("no_wr_during_stall", 32'(wrCount), 32'd1);
      releaseCycle = cycle;
      waitForce = 1'b0;
      waitDone(300);
      checkOutput("wr_after_release", 32'(wrCycles[1]), 32'(releaseCycle + 1));
      checkOutput("gap_after_stall", 32'(wrCycles[2] - wrCycles[1]), 32'(WR_GAP + 3));
      checkOutput("gap_after_stall2", 32'(wrCycles[3] - wrCycles[2]), 32'(WR_GAP + 3));

      // Upload of 3 bytes, din = addr + 0x10.
      dinOffset = 8'h10;
      applyStimulus(1'b1, 8'h04, 3, 1'b1, 1'b0);
      waitDone(300);
      checkOutput("ul_snk_count", 32'(snkCount), 32'd3);
      checkOutput("ul_no_wr", 32'(wrCount), 32'd0);
      checkOutput("ul_flag_cycles", 32'(flagCycles), 32'(SETUP + 3 * (RD_LAT + 1) + HOLD));

      // Zero-length download.
      applyStimulus(1'b0, 8'h00, 0, 1'b1, 1'b0);
      waitDone(100);
      checkOutput("len0_flag_cycles", 32'(flagCycles), 32'(SETUP + HOLD));
      checkOutput("len0_no_src_req", 32'(srcReqCycles), 32'd0);
      checkOutput("len0_no_wr", 32'(wrCount), 32'd0);

      // Asynchronous reset during the GAP of byte 2 of 8.
      applyStimulus(1'b0, 8'h22, 8, 1'b1, 1'b0);
      for (int i = 0; i < 300 && wrCount < 2; i++) @(negedge clk_sys);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async_reset_outputs", 32'(|{busy, done, src_req, snk_valid, snk_addr, snk_data,
                  ioctl_download, ioctl_upload, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout}), 32'd0);
      expWr.delete();
      expDone = 0;
      srcPos = srcBytes.size();
      doneBefore = doneCount;
      repeat (3) @(negedge clk_sys);
      reset_n = 1'b1;
      repeat (20) @(negedge clk_sys);
      checkOutput("no_done_after_reset", 32'(doneCount), 32'(doneBefore));
      applyStimulus(1'b0, 8'h23, 3, 1'b1, 1'b0);
      waitDone(300);
      checkOutput("post_reset_wr_count", 32'(wrCount), 32'd3);

      // A second start while busy must not disturb the running session.
      applyStimulus(1'b0, 8'h5A, 3, 1'b1, 1'b0);
      for (int i = 0; i < 300 && wrCount < 1; i++) @(negedge clk_sys);
      applyStimulus(1'b1, 8'h33, 9, 1'b0, 1'b0);
      waitDone(300);
      checkOutput("busy_start_wr_count", 32'(wrCount), 32'd3);
      checkOutput("busy_start_no_snk", 32'(snkCount), 32'd0);
      doneBefore = doneCount;
      repeat (30) @(negedge clk_sys);
      checkOutput("busy_start_no_extra_done", 32'(doneCount), 32'(doneBefore));
      checkOutput("busy_start_idle", 32'(busy), 32'd0);

      // Randomized sessions with a bursty source and random core stalls.
      srcAlways = 1'b0;
      waitRandom = 1'b1;
      for (int s = 0; s < 10; s++) begin
         dinOffset = 8'($urandom);
         applyStimulus(1'($urandom), 8'($urandom), $urandom_range(0, 6), 1'b1, 1'b0);
         waitDone(1500);
      end
      waitRandom = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
